// File: rtl/output_unit.sv
// Output byte queue between the core's '.' command and a ready/valid consumer.
// Full-queue writes stall the core unless the consumer drains a byte in the same cycle.
module output_unit #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     out_write,
  input  logic [7:0]               acc_out,
  output logic                     out_stall,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic                     out_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          enq;
  logic          deq;

  assign full      = (count_q == CW'(DEPTH));
  assign tx_valid  = (count_q != '0);
  assign out_empty = (count_q == '0);
  assign out_count = count_q;
  // A full queue still accepts a write when the head byte leaves this cycle.
  assign out_stall = out_write && full && !tx_ready;
  assign enq       = out_write && !out_stall;
  assign deq       = tx_valid && tx_ready;
  assign tx_data   = tx_valid ? mem_q[rd_ptr_q] : 8'h00;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; entries are only visible while counted as queued.
  always_ff @(posedge clk) begin
    if (enq && !reset) mem_q[wr_ptr_q] <= acc_out;
  end

endmodule
